// File: rtl/alu_result_queue.sv
// In-order result FIFO between ALU execute and writeback, with optional forwarding lookup.
// Forwarding is built only when ALU_RESULT_QUEUE_FWD_EN is defined.
module alu_result_queue #(
  parameter  int unsigned DEPTH      = 4,
  parameter  int unsigned REG_ADDR_W = 5,
  localparam int unsigned PTR_W      = $clog2(DEPTH),
  localparam int unsigned CNT_W      = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_result,
  input  logic                  in_is_zero,
  input  logic [REG_ADDR_W-1:0] in_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_result,
  output logic                  out_is_zero,
  output logic [REG_ADDR_W-1:0] out_rd,
  input  logic                  flush,
  output logic [CNT_W-1:0]      count,
  input  logic [REG_ADDR_W-1:0] q_rs1,
  input  logic [REG_ADDR_W-1:0] q_rs2,
  output logic                  fwd1_hit,
  output logic                  fwd2_hit,
  output logic [31:0]           fwd1_data,
  output logic [31:0]           fwd2_data
);

  logic [31:0]           mem_result [DEPTH];
  logic                  mem_zero   [DEPTH];
  logic [REG_ADDR_W-1:0] mem_rd     [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage carries no reset; only the window [rd_ptr, rd_ptr+count) is meaningful.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_result[wr_ptr] <= in_result;
      mem_zero[wr_ptr]   <= in_is_zero;
      mem_rd[wr_ptr]     <= in_rd;
    end
  end

  assign out_result  = out_valid ? mem_result[rd_ptr] : '0;
  assign out_is_zero = out_valid ? mem_zero[rd_ptr]   : 1'b0;
  assign out_rd      = out_valid ? mem_rd[rd_ptr]     : '0;

`ifdef ALU_RESULT_QUEUE_FWD_EN
  // Walk oldest to youngest so a later (younger) match overrides an earlier one.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_data = '0;
    idx       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (CNT_W'(i) < count && mem_rd[idx] != '0) begin
        if (mem_rd[idx] == q_rs1) begin
          fwd1_hit  = 1'b1;
          fwd1_data = mem_result[idx];
        end
        if (mem_rd[idx] == q_rs2) begin
          fwd2_hit  = 1'b1;
          fwd2_data = mem_result[idx];
        end
      end
    end
  end
`else
  logic unused_q;
  assign unused_q  = ^{q_rs1, q_rs2};
  assign fwd1_hit  = 1'b0;
  assign fwd2_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_data = '0;
`endif

endmodule

// File: tb/tb_alu_result_queue.sv
// Bench for alu_result_queue: directed scenarios plus randomized traffic against a queue model.
module tb_alu_result_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned RW    = 5;
  localparam int unsigned CW    = 3;

  typedef struct packed {
    logic [31:0]   result;
    logic          is_zero;
    logic [RW-1:0] rd;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_is_zero;
  logic [31:0]   in_result;
  logic [RW-1:0] in_rd;
  logic          out_valid, out_ready, out_is_zero;
  logic [31:0]   out_result;
  logic [RW-1:0] out_rd;
  logic          flush;
  logic [CW-1:0] count;
  logic [RW-1:0] q_rs1, q_rs2;
  logic          fwd1_hit, fwd2_hit;
  logic [31:0]   fwd1_data, fwd2_data;

  int checks   = 0;
  int failures = 0;
  entry_t mq[$];

  alu_result_queue #(.DEPTH(DEPTH), .REG_ADDR_W(RW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_is_zero(in_is_zero), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_is_zero(out_is_zero), .out_rd(out_rd),
    .flush(flush), .count(count),
    .q_rs1(q_rs1), .q_rs2(q_rs2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [31:0] res, input logic z,
                       input logic [RW-1:0] rd, input logic ordy, input logic fl);
    in_valid   = v;
    in_result  = res;
    in_is_zero = z;
    in_rd      = rd;
    out_ready  = ordy;
    flush      = fl;
  endtask

  // Advances one clock and applies the queue rules to the model.
  task automatic cycle();
    bit p, o, f;
    entry_t e;
    f = flush;
    p = in_valid && (mq.size() != DEPTH);
    o = out_ready && (mq.size() != 0);
    e = '{result: in_result, is_zero: in_is_zero, rd: in_rd};
    @(posedge clk);
    if (f) mq.delete();
    else begin
      if (o) void'(mq.pop_front());
      if (p) mq.push_back(e);
    end
    @(negedge clk);
  endtask

  function automatic entry_t exp_head();
    exp_head = (mq.size() != 0) ? mq[0] : '0;
  endfunction

  function automatic logic [32:0] exp_fwd(input logic [RW-1:0] q);
    exp_fwd = '0;
`ifdef ALU_RESULT_QUEUE_FWD_EN
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (q != '0 && mq[i].rd == q) begin
        exp_fwd = {1'b1, mq[i].result};
        break;
      end
    end
`endif
  endfunction

  function automatic logic [CW+1:0] exp_status();
    exp_status = {mq.size() != 0, mq.size() != DEPTH, CW'(mq.size())};
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h100 + i, 1'b0, RW'(i + 1), 1'b0, 1'b0);
      cycle();
    end
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    #1;
    checks++;
    if (count !== 3'd3) begin failures++; $display("FAIL reset_pre_count got=%0d exp=3", count); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++;
    if ({out_result, out_is_zero, out_rd} !== '0) begin
      failures++; $display("FAIL reset_out_data got=%h/%b/%0d exp=0", out_result, out_is_zero, out_rd);
    end
    mq.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill_drain();
    entry_t h;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h11 * (i + 1), 1'b0, RW'(i + 1), 1'b0, 1'b0);
      cycle();
    end
    drive(1'b1, 32'h55, 1'b0, 5'd5, 1'b0, 1'b0);
    #1;
    checks++;
    if (count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", count); end
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
    cycle();
    checks++;
    if (count !== 3'd4) begin failures++; $display("FAIL fifth_push_count got=%0d exp=4", count); end
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      h = exp_head();
      checks++;
      if (out_result !== 32'h11 * (i + 1) || h.result !== 32'h11 * (i + 1)) begin
        failures++; $display("FAIL drain_result[%0d] got=%h exp=%h", i, out_result, 32'h11 * (i + 1));
      end
      checks++;
      if ({out_valid, out_is_zero, out_rd} !== {1'b1, 1'b0, RW'(i + 1)}) begin
        failures++; $display("FAIL drain_meta[%0d] got=%b/%b/%0d exp=1/0/%0d", i, out_valid, out_is_zero, out_rd, i + 1);
      end
      cycle();
    end
    #1;
    checks++;
    if ({out_valid, count} !== {1'b0, 3'd0}) begin failures++; $display("FAIL drained got=%b/%0d exp=0/0", out_valid, count); end
  endtask

  task automatic test_wrap();
    drive(1'b1, 32'd1, 1'b0, 5'd1, 1'b0, 1'b0);
    cycle();
    for (int v = 1; v <= 10; v++) begin
      drive(v < 10, 32'(v + 1), 1'b0, 5'd1, 1'b1, 1'b0);
      #1;
      checks++;
      if (out_result !== 32'(v)) begin failures++; $display("FAIL wrap_out[%0d] got=%0d exp=%0d", v, out_result, v); end
      checks++;
      if (count !== 3'd1) begin failures++; $display("FAIL wrap_count[%0d] got=%0d exp=1", v, count); end
      cycle();
    end
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    #1;
    checks++;
    if (count !== 3'd0) begin failures++; $display("FAIL wrap_end_count got=%0d exp=0", count); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h70 + i, 1'b0, 5'd3, 1'b0, 1'b0);
      cycle();
    end
    drive(1'b1, 32'h99, 1'b0, 5'd3, 1'b1, 1'b1);
    cycle();
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    #1;
    checks++;
    if ({out_valid, count} !== {1'b0, 3'd0}) begin failures++; $display("FAIL flush_state got=%b/%0d exp=0/0", out_valid, count); end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (out_valid !== 1'b0 || out_result === 32'h99) begin
        failures++; $display("FAIL flush_leak[%0d] got=%b/%h exp=0/0", i, out_valid, out_result);
      end
    end
  endtask

  task automatic test_forwarding();
    drive(1'b1, 32'hA, 1'b0, 5'd5, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h0, 1'b1, 5'd0, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'hB, 1'b0, 5'd5, 1'b0, 1'b0); cycle();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    q_rs1 = 5'd5;
    q_rs2 = 5'd0;
    #1;
    checks++;
    if ({fwd1_hit, fwd1_data} !== exp_fwd(5'd5)) begin
      failures++; $display("FAIL fwd_rs5 got=%b/%h exp=%h", fwd1_hit, fwd1_data, exp_fwd(5'd5));
    end
    checks++;
    if ({fwd2_hit, fwd2_data} !== exp_fwd(5'd0)) begin
      failures++; $display("FAIL fwd_rs0 got=%b/%h exp=%h", fwd2_hit, fwd2_data, exp_fwd(5'd0));
    end
    // Pop the oldest rd5 while pushing a new rd7: popped entry still visible, pushed one not yet.
    drive(1'b1, 32'hC, 1'b0, 5'd7, 1'b1, 1'b0);
    q_rs2 = 5'd7;
    #1;
    checks++;
    if ({fwd2_hit, fwd2_data} !== exp_fwd(5'd7)) begin
      failures++; $display("FAIL fwd_same_cycle_push got=%b/%h exp=%h", fwd2_hit, fwd2_data, exp_fwd(5'd7));
    end
    cycle();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    #1;
    checks++;
    if ({fwd2_hit, fwd2_data} !== exp_fwd(5'd7)) begin
      failures++; $display("FAIL fwd_after_push got=%b/%h exp=%h", fwd2_hit, fwd2_data, exp_fwd(5'd7));
    end
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    cycle();
  endtask

  task automatic test_random();
    entry_t h;
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1,
            RW'($urandom_range(0, 3)), $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0);
      q_rs1 = RW'($urandom_range(0, 3));
      q_rs2 = RW'($urandom_range(0, 3));
      #1;
      h = exp_head();
      checks++;
      if ({out_valid, in_ready, count} !== exp_status()) begin
        failures++; $display("FAIL rnd_status[%0d] got=%b/%b/%0d exp=%b", n, out_valid, in_ready, count, exp_status());
      end
      checks++;
      if ({out_result, out_is_zero, out_rd} !== h) begin
        failures++; $display("FAIL rnd_head[%0d] got=%h/%b/%0d exp=%h", n, out_result, out_is_zero, out_rd, h);
      end
      checks++;
      if ({fwd1_hit, fwd1_data} !== exp_fwd(q_rs1)) begin
        failures++; $display("FAIL rnd_fwd1[%0d] got=%b/%h exp=%h", n, fwd1_hit, fwd1_data, exp_fwd(q_rs1));
      end
      checks++;
      if ({fwd2_hit, fwd2_data} !== exp_fwd(q_rs2)) begin
        failures++; $display("FAIL rnd_fwd2[%0d] got=%b/%h exp=%h", n, fwd2_hit, fwd2_data, exp_fwd(q_rs2));
      end
      cycle();
    end
  endtask

  initial begin
    rst = 1'b1;
    q_rs1 = '0;
    q_rs2 = '0;
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_flush();
    test_forwarding();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
